// File: rtl/pps_conditioner.sv
// pps_conditioner: synchronises and validates PPS, locks after a run of good periods,
// and emits one sec_tick per second from PPS when locked or from an internal divider otherwise.
module pps_conditioner #(
  parameter int CLK_HZ   = 100,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pps_raw,
  output logic sec_tick,
  output logic locked,
  output logic holdover,
  output logic pps_err
);
  localparam logic [1:0] SEARCH   = 2'd0;
  localparam logic [1:0] ACQUIRE  = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;
  localparam logic [1:0] HOLDOVER = 2'd3;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] PMAX = CNT_W'(CLK_HZ + TOL + 1);
  localparam logic [CNT_W-1:0] PLO  = CNT_W'(CLK_HZ - TOL);
  localparam logic [CNT_W-1:0] PHI  = CNT_W'(CLK_HZ + TOL);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(CLK_HZ);
  localparam logic [GW-1:0] GLOCK = GW'(LOCK_CNT);
  logic s1, s2, s3;
  logic [1:0] st, st_n;
  logic [CNT_W-1:0] p, d;
  logic [GW-1:0] g, g_n, g_inc;
  logic pps_edge, good, early, tmo, wrap, tick_n, err_n, dload;
  assign pps_edge = s2 & ~s3;
  assign good     = pps_edge && p >= PLO && p <= PHI;
  assign early    = pps_edge && p < PLO;
  assign tmo      = p == PMAX;
  assign wrap     = d == DMAX;
  assign g_inc    = g + 1'b1;
  // An edge landing on the saturated period counter counts as a timeout when locked.
  always_comb begin
    st_n   = st;
    g_n    = g;
    tick_n = wrap;
    err_n  = 1'b0;
    dload  = 1'b0;
    case (st)
      ACQUIRE: begin
        if (good) begin
          g_n = g_inc;
          if (g_inc == GLOCK) begin
            st_n   = LOCKED;
            tick_n = 1'b1;
            dload  = 1'b1;
          end
        end else if (pps_edge) begin
          g_n   = '0;
          err_n = 1'b1;
        end else if (tmo) begin
          st_n  = SEARCH;
          err_n = 1'b1;
        end
      end
      LOCKED: begin
        tick_n = good | tmo;
        err_n  = early | tmo;
        dload  = good | tmo;
        st_n   = (early | tmo) ? HOLDOVER : LOCKED;
      end
      default: begin
        st_n = pps_edge ? ACQUIRE : st;
        g_n  = pps_edge ? '0 : g;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s3, s2, s1} <= 3'b000;
      p            <= '0;
      d            <= CNT_W'(1);
      g            <= '0;
      st           <= SEARCH;
      sec_tick     <= 1'b0;
      pps_err      <= 1'b0;
      locked       <= 1'b0;
      holdover     <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, pps_raw};
      p            <= pps_edge ? CNT_W'(1) : tmo ? p : p + 1'b1;
      d            <= (dload | wrap) ? CNT_W'(1) : d + 1'b1;
      g            <= g_n;
      st           <= st_n;
      sec_tick     <= tick_n;
      pps_err      <= err_n;
      locked       <= st_n == LOCKED;
      holdover     <= st_n == HOLDOVER;
    end
  end
endmodule
